// File: rtl/uram_port_arbiter.sv
// uram_port_arbiter
// Shares one URAM bank's single read port and single write port between the
// core pipeline (requester 0) and the host/DMA loader (requester 1).
// The read and write ports are arbitrated independently every cycle. A
// READ_LATENCY-deep tag pipe routes each read response back to its issuer.
//
// Optional feature macro: URAM_ARB_ROUND_ROBIN_EN
//   defined   -> round-robin on contention (the requester not granted last wins)
//   undefined -> fixed priority, requester 0 wins on contention. The last-grant
//                bits are still kept, but they do not steer grants.
module uram_port_arbiter #(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDRESS_WIDTH = 14,
  parameter int READ_LATENCY  = 2
) (
  input  logic                     clock,
  input  logic                     reset_n,
  // read requesters
  input  logic                     rd0_valid,
  input  logic [ADDRESS_WIDTH-1:0] rd0_addr,
  output logic                     rd0_ready,
  input  logic                     rd1_valid,
  input  logic [ADDRESS_WIDTH-1:0] rd1_addr,
  output logic                     rd1_ready,
  // read responses
  output logic                     rsp0_valid,
  output logic [DATA_WIDTH-1:0]    rsp0_data,
  output logic                     rsp1_valid,
  output logic [DATA_WIDTH-1:0]    rsp1_data,
  // write requesters
  input  logic                     wr0_valid,
  input  logic [ADDRESS_WIDTH-1:0] wr0_addr,
  input  logic [DATA_WIDTH-1:0]    wr0_data,
  output logic                     wr0_ready,
  input  logic                     wr1_valid,
  input  logic [ADDRESS_WIDTH-1:0] wr1_addr,
  input  logic [DATA_WIDTH-1:0]    wr1_data,
  output logic                     wr1_ready,
  // memory ports
  output logic [ADDRESS_WIDTH-1:0] mem_raddr,
  input  logic [DATA_WIDTH-1:0]    mem_dout,
  output logic                     mem_wen,
  output logic [ADDRESS_WIDTH-1:0] mem_waddr,
  output logic [DATA_WIDTH-1:0]    mem_din
);

  // Last granted id per port. Reset to 1 so that requester 0 wins the first
  // contention.
  logic rd_last_q;
  logic wr_last_q;

  // Address held on the read port during idle cycles, so that it does not toggle
  logic [ADDRESS_WIDTH-1:0] raddr_q;

  // 1 when requester 1 should take the port this cycle
  logic rd_pick1;
  logic wr_pick1;

  logic rd_fire;
  logic wr_fire;

`ifdef URAM_ARB_ROUND_ROBIN_EN
  assign rd_pick1 = (rd0_valid && rd1_valid) ? ~rd_last_q : rd1_valid;
  assign wr_pick1 = (wr0_valid && wr1_valid) ? ~wr_last_q : wr1_valid;
`else
  assign rd_pick1 = rd1_valid && !rd0_valid;
  assign wr_pick1 = wr1_valid && !wr0_valid;
  // The history bits are kept for compatibility but do not steer grants here
  logic last_grant_unused;
  assign last_grant_unused = rd_last_q ^ wr_last_q;
`endif

  // Grants: combinational from the valids. Forced low while in reset.
  assign rd0_ready = reset_n && rd0_valid && !rd_pick1;
  assign rd1_ready = reset_n && rd1_valid &&  rd_pick1;
  assign wr0_ready = reset_n && wr0_valid && !wr_pick1;
  assign wr1_ready = reset_n && wr1_valid &&  wr_pick1;

  assign rd_fire = rd0_ready || rd1_ready;
  assign wr_fire = wr0_ready || wr1_ready;

  // Read port: the granted address, otherwise the last one issued
  assign mem_raddr = rd1_ready ? rd1_addr :
                     rd0_ready ? rd0_addr : raddr_q;

  // Write port: driven straight from the winning requester
  assign mem_wen   = wr_fire;
  assign mem_waddr = wr1_ready ? wr1_addr : wr0_addr;
  assign mem_din   = wr1_ready ? wr1_data : wr0_data;

  // Arbiter history and held read address, updated only on a handshake
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_last_q <= 1'b1;
      wr_last_q <= 1'b1;
      raddr_q   <= '0;
    end else begin
      if (rd_fire) begin
        rd_last_q <= rd1_ready;
        raddr_q   <= mem_raddr;
      end
      if (wr_fire) begin
        wr_last_q <= wr1_ready;
      end
    end
  end

  // Tag pipe: one stage per cycle of memory read latency
  logic tag_vld_p [READ_LATENCY];
  logic tag_id_p  [READ_LATENCY];

  // Tag valid bits. Clearing them drops any read still in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        tag_vld_p[i] <= 1'b0;
      end
    end else begin
      // ---- stage 0: issue cycle -> first tag register ----
      tag_vld_p[0] <= rd_fire;
      // ---- stages 1..READ_LATENCY-1: follow the memory read pipe ----
      for (int i = 1; i < READ_LATENCY; i++) begin
        tag_vld_p[i] <= tag_vld_p[i-1];
      end
    end
  end

  // Tag ids travel with the valid bits. They are only meaningful while the
  // matching valid bit is set.
  always_ff @(posedge clock) begin
    tag_id_p[0] <= rd1_ready;
    for (int i = 1; i < READ_LATENCY; i++) begin
      tag_id_p[i] <= tag_id_p[i-1];
    end
  end

  // ---- tag exit: lines up with mem_dout ----
  assign rsp0_valid = reset_n && tag_vld_p[READ_LATENCY-1] && !tag_id_p[READ_LATENCY-1];
  assign rsp1_valid = reset_n && tag_vld_p[READ_LATENCY-1] &&  tag_id_p[READ_LATENCY-1];
  assign rsp0_data  = mem_dout;
  assign rsp1_data  = mem_dout;

endmodule
